// File: rtl/pi_loop_sequencer.sv
// Sequencer for one pi_controller: bumpless start (clear, then ramp the setpoint from
// the measured input), sample-aligned coefficient updates, lock and saturation detection.
module pi_loop_sequencer #(
  parameter int inputBitSize  = 27,
  parameter int coeffBitSize  = 27,
  parameter int outputBitSize = 16,
  parameter int CNT_BITS      = 8,
  parameter int CLEAR_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [inputBitSize-1:0]  target_setpoint,
  input  logic [inputBitSize-1:0]  ramp_step,
  input  logic [inputBitSize-1:0]  lock_threshold,
  input  logic [CNT_BITS-1:0]      lock_count,
  input  logic [CNT_BITS-1:0]      sat_limit,
  input  logic [coeffBitSize-1:0]  kp_in,
  input  logic [coeffBitSize-1:0]  ti_in,
  input  logic                     coeff_update,
  input  logic [inputBitSize-1:0]  sample_in,
  input  logic                     sample_valid,
  input  logic [outputBitSize-1:0] pi_output_in,
  input  logic                     pi_output_valid_in,
  output logic [inputBitSize-1:0]  pi_setpoint,
  output logic [coeffBitSize-1:0]  pi_kp_coefficient,
  output logic [coeffBitSize-1:0]  pi_ti_coefficient,
  output logic                     reset_pi,
  output logic                     enable_pi,
  output logic                     pi_limiting,
  output logic [2:0]               state,
  output logic                     locked,
  output logic                     fault
);

  localparam int EXT_W = inputBitSize + 1;
  localparam logic [outputBitSize-1:0] OUT_MAX = {1'b0, {(outputBitSize-1){1'b1}}};
  localparam logic [outputBitSize-1:0] OUT_MIN = {1'b1, {(outputBitSize-1){1'b0}}};
  localparam logic [3:0] CLR_LAST = 4'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RAMP  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  function automatic logic [EXT_W-1:0] abs_ext(input logic signed [EXT_W-1:0] v);
    return v[EXT_W-1] ? unsigned'(-v) : unsigned'(v);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (&c) ? c : c + CNT_BITS'(1);
  endfunction

  function automatic logic is_railed(input logic [outputBitSize-1:0] v);
    return (v == OUT_MAX) || (v == OUT_MIN);
  endfunction

  state_t                    state_q, state_nxt;
  logic [inputBitSize-1:0]   sp_nxt;
  logic [coeffBitSize-1:0]   kp_nxt, ti_nxt;
  logic [coeffBitSize-1:0]   shadow_kp_q, shadow_ti_q, shadow_kp_nxt, shadow_ti_nxt;
  logic                      pending_q, pending_nxt;
  logic                      lim_nxt, locked_nxt, run_nxt;
  logic [CNT_BITS-1:0]       lock_cnt_q, lock_cnt_nxt;
  logic [CNT_BITS-1:0]       sat_cnt_q, sat_cnt_nxt;
  logic [3:0]                clr_cnt_q, clr_cnt_nxt;

  logic signed [inputBitSize-1:0] tgt_s, sp_s, smp_s;
  logic signed [EXT_W-1:0]        ramp_d, lock_e, step_s, ramp_sum;
  logic [EXT_W-1:0]               ramp_abs, lock_abs, step_ext, thr_ext;
  logic                           run_q, lock_miss;

  // Error terms are one bit wider than the operands so full-scale swings cannot wrap.
  assign tgt_s    = signed'(target_setpoint);
  assign sp_s     = signed'(pi_setpoint);
  assign smp_s    = signed'(sample_in);
  assign step_ext = {1'b0, ramp_step};
  assign thr_ext  = {1'b0, lock_threshold};
  assign step_s   = signed'(step_ext);
  assign ramp_d   = EXT_W'(tgt_s) - EXT_W'(sp_s);
  assign lock_e   = EXT_W'(sp_s) - EXT_W'(smp_s);
  assign ramp_abs = abs_ext(ramp_d);
  assign lock_abs = abs_ext(lock_e);
  assign ramp_sum = ramp_d[EXT_W-1] ? (EXT_W'(sp_s) - step_s) : (EXT_W'(sp_s) + step_s);
  assign run_q    = (state_q == RAMP) || (state_q == HOLD);
  assign lock_miss = sample_valid && (lock_abs > thr_ext);
  assign state    = state_q;

  always_comb begin
    state_nxt     = state_q;
    sp_nxt        = pi_setpoint;
    kp_nxt        = pi_kp_coefficient;
    ti_nxt        = pi_ti_coefficient;
    shadow_kp_nxt = shadow_kp_q;
    shadow_ti_nxt = shadow_ti_q;
    pending_nxt   = pending_q;
    lim_nxt       = pi_limiting;
    locked_nxt    = locked;
    lock_cnt_nxt  = lock_cnt_q;
    sat_cnt_nxt   = sat_cnt_q;
    clr_cnt_nxt   = clr_cnt_q;

    // While the loop runs, coefficients only move on a sample boundary; a fresh
    // update arriving on the same edge stays pending for the next boundary.
    if (pending_q && (!run_q || sample_valid)) begin
      kp_nxt      = shadow_kp_q;
      ti_nxt      = shadow_ti_q;
      pending_nxt = 1'b0;
    end
    if (coeff_update) begin
      shadow_kp_nxt = kp_in;
      shadow_ti_nxt = ti_in;
      pending_nxt   = 1'b1;
    end

    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == CLR_LAST) state_nxt = RAMP;
        else                       clr_cnt_nxt = clr_cnt_q + 4'd1;
      end
      RAMP: begin
        if (sample_valid) begin
          if ((ramp_step == '0) || (ramp_abs <= step_ext)) begin
            sp_nxt    = target_setpoint;
            state_nxt = HOLD;
          end else begin
            sp_nxt = ramp_sum[inputBitSize-1:0];
          end
        end
      end
      HOLD: begin
        if (target_setpoint != pi_setpoint) begin
          state_nxt    = RAMP;
          locked_nxt   = 1'b0;
          lock_cnt_nxt = '0;
        end else begin
          if (sample_valid) lock_cnt_nxt = lock_miss ? '0 : sat_inc(lock_cnt_q);
          locked_nxt = (lock_cnt_nxt >= lock_count) && !lock_miss;
        end
      end
      default: ;
    endcase

    // Saturation watch overrides the ramp/hold transition when the limit is hit.
    if (run_q && pi_output_valid_in) begin
      lim_nxt     = is_railed(pi_output_in);
      sat_cnt_nxt = lim_nxt ? sat_inc(sat_cnt_q) : '0;
      if ((sat_limit != '0) && (sat_cnt_nxt >= sat_limit)) state_nxt = FAULT;
    end

    if (stop) begin
      state_nxt    = IDLE;
      lock_cnt_nxt = '0;
      sat_cnt_nxt  = '0;
      clr_cnt_nxt  = '0;
    end else if (start) begin
      state_nxt    = CLEAR;
      lock_cnt_nxt = '0;
      sat_cnt_nxt  = '0;
      clr_cnt_nxt  = '0;
      if (sample_valid) sp_nxt = sample_in;
    end

    run_nxt = (state_nxt == RAMP) || (state_nxt == HOLD);
    if (!run_nxt) begin
      lim_nxt    = 1'b0;
      locked_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      pi_setpoint       <= '0;
      pi_kp_coefficient <= '0;
      pi_ti_coefficient <= '0;
      shadow_kp_q       <= '0;
      shadow_ti_q       <= '0;
      pending_q         <= 1'b0;
      reset_pi          <= 1'b1;
      enable_pi         <= 1'b0;
      pi_limiting       <= 1'b0;
      locked            <= 1'b0;
      fault             <= 1'b0;
      lock_cnt_q        <= '0;
      sat_cnt_q         <= '0;
      clr_cnt_q         <= '0;
    end else begin
      state_q           <= state_nxt;
      pi_setpoint       <= sp_nxt;
      pi_kp_coefficient <= kp_nxt;
      pi_ti_coefficient <= ti_nxt;
      shadow_kp_q       <= shadow_kp_nxt;
      shadow_ti_q       <= shadow_ti_nxt;
      pending_q         <= pending_nxt;
      reset_pi          <= !run_nxt;
      enable_pi         <= run_nxt;
      pi_limiting       <= lim_nxt;
      locked            <= locked_nxt;
      fault             <= (state_nxt == FAULT);
      lock_cnt_q        <= lock_cnt_nxt;
      sat_cnt_q         <= sat_cnt_nxt;
      clr_cnt_q         <= clr_cnt_nxt;
    end
  end

endmodule
